// File: rtl/mem_march_tester_if.sv
// RAM port bundle for the march tester.
// The master (tester) drives the byte write enables, byte address and write data.
// The slave (RAM) returns the read data one cycle after it is given an address.
interface mem_march_tester_if;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    output ram_wen,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_wen,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_march_tester.sv
// Four-phase march BIST sequencer for a synchronous 32-bit data RAM.
// The four phases are: write up, read up, write-inverse down, read-inverse down.
// Ports:
//   clk, reset       system clock and synchronous active-high reset
//   start, seed      start request (accepted in IDLE/DONE only) and pattern seed
//   busy, done, pass run status; pass is meaningful while done=1
//   err_cnt          saturating mismatch count
//   first_err_addr   byte address of the first mismatch
//   first_err_data   data read at the first mismatch
//   ram              RAM port (wen/addr/wdata out, rdata in, 1-cycle read latency)
module mem_march_tester #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [31:0]          first_err_addr,
  output logic [31:0]          first_err_data,
  mem_march_tester_if.master   ram
);

  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] A_LAST  = {ADDR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, W_UP, R_UP, W_DN, R_DN, DRAIN, DONE
  } state_t;

  function automatic logic [DATA_W-1:0] byte_addr(input logic [ADDR_W-1:0] a);
    return DATA_W'({a, 2'b00});
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    return s ^ DATA_W'(a);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [DATA_W-1:0]   exp_addr_q, exp_addr_d;
  logic                cmp_v_q, cmp_v_d;
  logic                busy_d, done_d, pass_d;
  logic [ERR_W-1:0]    err_d;
  logic [DATA_W-1:0]   first_addr_d, first_data_d;
  logic [3:0]          wen_d;
  logic [DATA_W-1:0]   addr_d, wdata_d;
  logic                start_ok_c, mismatch_c;

  // Next-state, compare stage and next RAM command.
  // RAM outputs are registered from the next state, so state_q/a_q always
  // describe the operation currently presented on the RAM port.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    seed_d       = seed_q;
    exp_d        = exp_q;
    exp_addr_d   = exp_addr_q;
    cmp_v_d      = 1'b0;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    err_d        = err_cnt;
    first_addr_d = first_err_addr;
    first_data_d = first_err_data;
    wen_d        = 4'h0;
    addr_d       = '0;
    wdata_d      = '0;
    start_ok_c   = start && ((state_q == IDLE) || (state_q == DONE));
    mismatch_c   = cmp_v_q && (ram.ram_rdata != exp_q);

    // Compare stage runs regardless of the current phase.
    if (mismatch_c) begin
      if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_W'(1);
      if (err_cnt == '0) begin
        first_addr_d = exp_addr_q;
        first_data_d = ram.ram_rdata;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          seed_d       = seed;
          state_d      = W_UP;
          a_d          = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          first_addr_d = '0;
          first_data_d = '0;
        end
      end
      W_UP: begin
        if (a_q == A_LAST) begin
          state_d = R_UP;
          a_d     = '0;
        end else begin
          a_d = a_q + ADDR_W'(1);
        end
      end
      R_UP: begin
        cmp_v_d    = 1'b1;
        exp_d      = pat(seed_q, a_q);
        exp_addr_d = byte_addr(a_q);
        if (a_q == A_LAST) begin
          state_d = W_DN;
          a_d     = A_LAST;
        end else begin
          a_d = a_q + ADDR_W'(1);
        end
      end
      W_DN: begin
        if (a_q == '0) begin
          state_d = R_DN;
          a_d     = A_LAST;
        end else begin
          a_d = a_q - ADDR_W'(1);
        end
      end
      R_DN: begin
        cmp_v_d    = 1'b1;
        exp_d      = ~pat(seed_q, a_q);
        exp_addr_d = byte_addr(a_q);
        if (a_q == '0) state_d = DRAIN;
        else           a_d = a_q - ADDR_W'(1);
      end
      DRAIN: begin
        // err_d already includes the final R_DN compare.
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      default: state_d = IDLE;
    endcase

    // RAM command for the cycle that follows.
    case (state_d)
      W_UP: begin
        wen_d   = 4'hF;
        addr_d  = byte_addr(a_d);
        wdata_d = pat(seed_d, a_d);
      end
      W_DN: begin
        wen_d   = 4'hF;
        addr_d  = byte_addr(a_d);
        wdata_d = ~pat(seed_d, a_d);
      end
      R_UP, R_DN: addr_d = byte_addr(a_d);
      default: ;
    endcase
  end

  // State and output registers; reset overrides everything including start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      a_q            <= '0;
      seed_q         <= '0;
      exp_q          <= '0;
      exp_addr_q     <= '0;
      cmp_v_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      ram.ram_wen    <= 4'h0;
      ram.ram_addr   <= '0;
      ram.ram_wdata  <= '0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      seed_q         <= seed_d;
      exp_q          <= exp_d;
      exp_addr_q     <= exp_addr_d;
      cmp_v_q        <= cmp_v_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_cnt        <= err_d;
      first_err_addr <= first_addr_d;
      first_err_data <= first_data_d;
      ram.ram_wen    <= wen_d;
      ram.ram_addr   <= addr_d;
      ram.ram_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_march_tester.sv
// Self-checking bench for mem_march_tester.
// It contains a behavioural RAM with selectable faults, a queue of expected
// writes and a queue of expected end-of-run results.
module tb_mem_march_tester;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned ERR_W      = 16;
  localparam int          WORDS      = 1 << ADDR_W;
  localparam int          RUN_CYCLES = 4 * WORDS + 1;
  localparam int          TIMEOUT    = 1200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       seed;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [31:0]       first_err_addr, first_err_data;

  mem_march_tester_if ram_if ();

  mem_march_tester #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .ram            (ram_if)
  );

  always #5 clk = ~clk;

  // RAM model. Mode 0 is ideal, mode 1 has bit 0 of word 0x10 stuck at 0,
  // and mode 2 always reads zero.
  logic [31:0] mem [WORDS];
  int          mode = 0;

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] idx);
    logic [31:0] v;
    v = mem[idx];
    if (mode == 1 && idx == 8'h10) v[0] = 1'b0;
    if (mode == 2) v = 32'h0;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_if.ram_wen[b]) mem[ram_if.ram_addr[ADDR_W+1:2]][8*b +: 8] <= ram_if.ram_wdata[8*b +: 8];
    ram_if.ram_rdata <= rd_word(ram_if.ram_addr[ADDR_W+1:2]);
  end

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [ERR_W-1:0] err;
    logic             pass;
    logic [31:0]      faddr;
    logic [31:0]      fdata;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic push_writes(input logic [31:0] s);
    wr_t w;
    for (int a = 0; a < WORDS; a++) begin
      w.wen = 4'hF; w.addr = 32'(a) << 2; w.data = s ^ 32'(a);
      wq.push_back(w);
    end
    for (int a = WORDS - 1; a >= 0; a--) begin
      w.wen = 4'hF; w.addr = 32'(a) << 2; w.data = ~(s ^ 32'(a));
      wq.push_back(w);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "busy",   32'(busy), 32'h0);
    chk(tag, "done",   32'(done), 32'h0);
    chk(tag, "pass",   32'(pass), 32'h0);
    chk(tag, "err",    32'(err_cnt), 32'h0);
    chk(tag, "faddr",  first_err_addr, 32'h0);
    chk(tag, "fdata",  first_err_data, 32'h0);
    chk(tag, "wen",    32'(ram_if.ram_wen), 32'h0);
    chk(tag, "addr",   ram_if.ram_addr, 32'h0);
    chk(tag, "wdata",  ram_if.ram_wdata, 32'h0);
  endtask

  // One march run. reset_at/restart_at (-1 = unused) inject a reset or an
  // extra start after that many cycles into the run.
  task automatic do_run(input string tag, input logic [31:0] s, input res_t exp_r,
                        input int reset_at, input int restart_at);
    wr_t  w;
    res_t r;
    int   cyc;
    bit   finished, aborted;
    push_writes(s);
    rq.push_back(exp_r);
    @(posedge clk); #1;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; finished = 0; aborted = 0;
    while (!finished && !aborted && cyc < TIMEOUT) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk(tag, "start_done_low", 32'(done), 32'h0);
        chk(tag, "start_busy",     32'(busy), 32'h1);
        chk(tag, "start_err_clr",  32'(err_cnt), 32'h0);
        chk(tag, "start_faddr_clr", first_err_addr, 32'h0);
      end
      if (ram_if.ram_wen != 4'h0) begin
        if (wq.size() == 0) begin
          chk(tag, "unexpected_write_wen", 32'(ram_if.ram_wen), 32'h0);
        end else begin
          w = wq.pop_front();
          chk(tag, "wr_wen",  32'(ram_if.ram_wen), 32'(w.wen));
          chk(tag, "wr_addr", ram_if.ram_addr, w.addr);
          chk(tag, "wr_data", ram_if.ram_wdata, w.data);
        end
      end
      if (done) begin
        finished = 1;
      end else begin
        if (cyc == reset_at) reset = 1'b1;
        if (cyc == restart_at) begin
          start = 1'b1;
          seed  = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
          reset   = 1'b0;
          aborted = 1;
        end
        start = 1'b0;
        seed  = s;
      end
    end
    if (aborted) begin
      @(negedge clk);
      chk_all_zero({tag, "_after_reset"});
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk(tag, "post_reset_wen", 32'(ram_if.ram_wen), 32'h0);
        chk(tag, "post_reset_busy", 32'(busy), 32'h0);
      end
      wq.delete();
      rq.delete();
    end else begin
      chk(tag, "cycles", 32'(cyc), 32'(RUN_CYCLES));
      chk(tag, "writes_left", 32'(wq.size()), 32'h0);
      wq.delete();
      r = rq.pop_front();
      chk(tag, "busy_end", 32'(busy), 32'h0);
      chk(tag, "err_cnt",  32'(err_cnt), 32'(r.err));
      chk(tag, "pass",     32'(pass), 32'(r.pass));
      chk(tag, "faddr",    first_err_addr, r.faddr);
      chk(tag, "fdata",    first_err_data, r.fdata);
    end
  endtask

  initial begin
    res_t ok, stuck, zero;
    ok.err    = '0;           ok.pass    = 1'b1; ok.faddr    = 32'h0;  ok.fdata    = 32'h0;
    stuck.err = ERR_W'(1);    stuck.pass = 1'b0; stuck.faddr = 32'h40; stuck.fdata = 32'hFFFF_FFEE;
    zero.err  = ERR_W'(511);  zero.pass  = 1'b0; zero.faddr  = 32'h4;  zero.fdata  = 32'h0;

    reset = 1'b1;
    start = 1'b0;
    seed  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    // start together with reset: reset wins
    seed  = 32'h1111_1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("reset_vs_start", "busy", 32'(busy), 32'h0);
    chk("reset_vs_start", "wen",  32'(ram_if.ram_wen), 32'h0);
    reset = 1'b0;

    mode = 0; do_run("ideal_seed0", 32'h0, ok, -1, -1);
    mode = 1; do_run("stuck_bit",   32'h0, stuck, -1, -1);
    mode = 2; do_run("read_zero",   32'h0, zero, -1, -1);
    mode = 0; do_run("seed_a5a5",   32'hA5A5_0000, ok, -1, -1);
    do_run("restart_from_done", 32'h0F0F_F0F0, ok, -1, -1);
    do_run("reset_in_wdn", 32'h3C3C_C3C3, ok, 600, -1);
    do_run("after_reset",  32'h1357_9BDF, ok, -1, -1);
    do_run("start_ignored", 32'h1234_5678, ok, -1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
